// File: rtl/shim_status_pkg.sv
// Shared definitions for the SHIM hardware status event log: group codes,
// flattened status-vector geometry and event word layout.
package shim_status_pkg;

  localparam int unsigned NUM_GROUPS = 17;
  localparam int unsigned NUM_BOARDS = 8;
  localparam int unsigned NUM_BITS   = NUM_GROUPS * NUM_BOARDS;

  localparam int unsigned GRP_SPI_OFF               = 0;
  localparam int unsigned GRP_OVER_THRESH           = 1;
  localparam int unsigned GRP_THRESH_UNDERFLOW      = 2;
  localparam int unsigned GRP_THRESH_OVERFLOW       = 3;
  localparam int unsigned GRP_BAD_TRIG_CMD          = 4;
  localparam int unsigned GRP_TRIG_DATA_BUF_OVF     = 5;
  localparam int unsigned GRP_DAC_BOOT_FAIL         = 6;
  localparam int unsigned GRP_BAD_DAC_CMD           = 7;
  localparam int unsigned GRP_DAC_CAL_OOB           = 8;
  localparam int unsigned GRP_DAC_VAL_OOB           = 9;
  localparam int unsigned GRP_DAC_CMD_BUF_UNDERFLOW = 10;
  localparam int unsigned GRP_UNEXP_DAC_TRIG        = 11;
  localparam int unsigned GRP_ADC_BOOT_FAIL         = 12;
  localparam int unsigned GRP_BAD_ADC_CMD           = 13;
  localparam int unsigned GRP_ADC_CMD_BUF_UNDERFLOW = 14;
  localparam int unsigned GRP_ADC_DATA_BUF_OVERFLOW = 15;
  localparam int unsigned GRP_UNEXP_ADC_TRIG        = 16;

  // Event word = {timestamp, group, board}; the low byte is also the bit index.
  localparam int unsigned EVT_BOARD_LSB = 0;
  localparam int unsigned EVT_BOARD_W   = 3;
  localparam int unsigned EVT_GROUP_LSB = 3;
  localparam int unsigned EVT_GROUP_W   = 5;
  localparam int unsigned EVT_TS_LSB    = 8;
  localparam int unsigned EVT_CODE_W    = EVT_GROUP_W + EVT_BOARD_W;

  typedef logic [EVT_CODE_W-1:0] evt_code_t;

  typedef struct packed {
    logic      valid;
    evt_code_t code;
  } fault_t;

endpackage

// File: rtl/shim_evt_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; a write is
// accepted while full when a read happens on the same edge.
module shim_evt_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  // Head is forced to zero when empty so the output is clean after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/shim_hw_status_event_log.sv
// Rising-edge event logger for synchronized SHIM status vectors: pending
// bits, fixed-priority serialization into a timestamped FIFO, sticky flags.
module shim_hw_status_event_log
  import shim_status_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TS_WIDTH   = 24
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          spi_off_sync,
  input  logic [7:0]                    over_thresh_sync,
  input  logic [7:0]                    thresh_underflow_sync,
  input  logic [7:0]                    thresh_overflow_sync,
  input  logic                          bad_trig_cmd_sync,
  input  logic                          trig_data_buf_overflow_sync,
  input  logic [7:0]                    dac_boot_fail_sync,
  input  logic [7:0]                    bad_dac_cmd_sync,
  input  logic [7:0]                    dac_cal_oob_sync,
  input  logic [7:0]                    dac_val_oob_sync,
  input  logic [7:0]                    dac_cmd_buf_underflow_sync,
  input  logic [7:0]                    unexp_dac_trig_sync,
  input  logic [7:0]                    adc_boot_fail_sync,
  input  logic [7:0]                    bad_adc_cmd_sync,
  input  logic [7:0]                    adc_cmd_buf_underflow_sync,
  input  logic [7:0]                    adc_data_buf_overflow_sync,
  input  logic [7:0]                    unexp_adc_trig_sync,
  input  logic                          clear,
  input  logic                          evt_rd_en,
  output logic [TS_WIDTH+7:0]           evt_data,
  output logic                          evt_valid,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic [8:0]                    first_fault,
  output logic                          evt_overflow,
  output logic                          irq
);

  localparam int unsigned EW = TS_WIDTH + EVT_TS_LSB;

  logic [NUM_BITS-1:0] in_vec;
  logic [NUM_BITS-1:0] prev;
  logic [NUM_BITS-1:0] pending;
  logic [NUM_BITS-1:0] edges;
  logic [NUM_BITS-1:0] push_mask;
  evt_code_t           sel;
  logic                any_pend;
  logic                fifo_full;
  logic                fifo_empty;
  logic                can_pop;
  logic                push;
  logic                ov_new;
  logic [TS_WIDTH-1:0] ts;
  fault_t              ff_q;
  logic                ov_q;

  // Flat status vector indexed group*8+board; absent boards of 1-bit groups stay 0.
  always_comb begin
    in_vec = '0;
    in_vec[GRP_SPI_OFF*NUM_BOARDS]                                      = spi_off_sync;
    in_vec[GRP_OVER_THRESH*NUM_BOARDS +: NUM_BOARDS]                    = over_thresh_sync;
    in_vec[GRP_THRESH_UNDERFLOW*NUM_BOARDS +: NUM_BOARDS]               = thresh_underflow_sync;
    in_vec[GRP_THRESH_OVERFLOW*NUM_BOARDS +: NUM_BOARDS]                = thresh_overflow_sync;
    in_vec[GRP_BAD_TRIG_CMD*NUM_BOARDS]                                 = bad_trig_cmd_sync;
    in_vec[GRP_TRIG_DATA_BUF_OVF*NUM_BOARDS]                            = trig_data_buf_overflow_sync;
    in_vec[GRP_DAC_BOOT_FAIL*NUM_BOARDS +: NUM_BOARDS]                  = dac_boot_fail_sync;
    in_vec[GRP_BAD_DAC_CMD*NUM_BOARDS +: NUM_BOARDS]                    = bad_dac_cmd_sync;
    in_vec[GRP_DAC_CAL_OOB*NUM_BOARDS +: NUM_BOARDS]                    = dac_cal_oob_sync;
    in_vec[GRP_DAC_VAL_OOB*NUM_BOARDS +: NUM_BOARDS]                    = dac_val_oob_sync;
    in_vec[GRP_DAC_CMD_BUF_UNDERFLOW*NUM_BOARDS +: NUM_BOARDS]          = dac_cmd_buf_underflow_sync;
    in_vec[GRP_UNEXP_DAC_TRIG*NUM_BOARDS +: NUM_BOARDS]                 = unexp_dac_trig_sync;
    in_vec[GRP_ADC_BOOT_FAIL*NUM_BOARDS +: NUM_BOARDS]                  = adc_boot_fail_sync;
    in_vec[GRP_BAD_ADC_CMD*NUM_BOARDS +: NUM_BOARDS]                    = bad_adc_cmd_sync;
    in_vec[GRP_ADC_CMD_BUF_UNDERFLOW*NUM_BOARDS +: NUM_BOARDS]          = adc_cmd_buf_underflow_sync;
    in_vec[GRP_ADC_DATA_BUF_OVERFLOW*NUM_BOARDS +: NUM_BOARDS]          = adc_data_buf_overflow_sync;
    in_vec[GRP_UNEXP_ADC_TRIG*NUM_BOARDS +: NUM_BOARDS]                 = unexp_adc_trig_sync;
  end

  // Downward scan so the lowest set index (lowest group, then board) wins.
  always_comb begin
    sel      = '0;
    any_pend = 1'b0;
    for (int unsigned i = NUM_BITS; i > 0; i--) begin
      if (pending[i-1]) begin
        sel      = EVT_CODE_W'(i - 1);
        any_pend = 1'b1;
      end
    end
  end

  assign edges     = in_vec & ~prev;
  assign can_pop   = evt_rd_en & ~fifo_empty;
  assign push      = any_pend & (~fifo_full | can_pop);
  assign push_mask = push ? (NUM_BITS'(1) << sel) : '0;
  // An edge on a bit being pushed this cycle is a fresh event, not an overflow.
  assign ov_new    = |(edges & pending & ~push_mask);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      prev    <= '0;
      pending <= '0;
      ts      <= '0;
      ff_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      prev    <= in_vec;
      pending <= (pending & ~push_mask) | edges;
      ts      <= ts + 1'b1;
      if (clear || !ff_q.valid) begin
        ff_q <= push ? fault_t'{valid: 1'b1, code: sel} : '0;
      end
      ov_q <= ov_new | (ov_q & ~clear);
    end
  end

  shim_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .wr_en   (push),
    .wr_data ({ts, sel}),
    .rd_en   (evt_rd_en),
    .rd_data (evt_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (evt_count)
  );

  assign evt_valid    = ~fifo_empty;
  assign first_fault  = ff_q;
  assign evt_overflow = ov_q;
  assign irq          = evt_valid | ov_q;

endmodule

// File: tb/tb_shim_hw_status_event_log.sv
// Randomized bench for shim_hw_status_event_log against a queue-based
// behavioural model, plus directed scenarios with literal expectations.
module tb_shim_hw_status_event_log;

  localparam int DEPTH = 16;
  localparam int TSW   = 24;
  localparam int W     = TSW + 8;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [7:0]   gin [17];
  logic         clear = 1'b0;
  logic         evt_rd_en = 1'b0;
  logic [W-1:0] evt_data;
  logic         evt_valid;
  logic [4:0]   evt_count;
  logic [8:0]   first_fault;
  logic         evt_overflow;
  logic         irq;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  shim_hw_status_event_log #(
    .FIFO_DEPTH (DEPTH),
    .TS_WIDTH   (TSW)
  ) dut (
    .aclk                        (aclk),
    .areset                      (areset),
    .spi_off_sync                (gin[0][0]),
    .over_thresh_sync            (gin[1]),
    .thresh_underflow_sync       (gin[2]),
    .thresh_overflow_sync        (gin[3]),
    .bad_trig_cmd_sync           (gin[4][0]),
    .trig_data_buf_overflow_sync (gin[5][0]),
    .dac_boot_fail_sync          (gin[6]),
    .bad_dac_cmd_sync            (gin[7]),
    .dac_cal_oob_sync            (gin[8]),
    .dac_val_oob_sync            (gin[9]),
    .dac_cmd_buf_underflow_sync  (gin[10]),
    .unexp_dac_trig_sync         (gin[11]),
    .adc_boot_fail_sync          (gin[12]),
    .bad_adc_cmd_sync            (gin[13]),
    .adc_cmd_buf_underflow_sync  (gin[14]),
    .adc_data_buf_overflow_sync  (gin[15]),
    .unexp_adc_trig_sync         (gin[16]),
    .clear                       (clear),
    .evt_rd_en                   (evt_rd_en),
    .evt_data                    (evt_data),
    .evt_valid                   (evt_valid),
    .evt_count                   (evt_count),
    .first_fault                 (first_fault),
    .evt_overflow                (evt_overflow),
    .irq                         (irq)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           mprev [136];
  bit           mpend [136];
  logic [W-1:0] mq [$];
  int unsigned  mts;
  logic [8:0]   mff;
  bit           mov;

  function automatic bit in_bit(input int i);
    int g = i / 8;
    int b = i % 8;
    if ((g == 0 || g == 4 || g == 5) && b != 0) return 1'b0;
    return gin[g][b];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 136; i++) begin
      mprev[i] = 1'b0;
      mpend[i] = 1'b0;
    end
    mq.delete();
    mts = 0;
    mff = '0;
    mov = 1'b0;
  endtask

  task automatic model_step();
    bit pop, push, ov;
    int sel;
    bit cur [136];
    pop = evt_rd_en && (mq.size() > 0);
    sel = -1;
    for (int i = 0; i < 136; i++) begin
      if (mpend[i]) begin
        sel = i;
        break;
      end
    end
    push = (sel >= 0) && (mq.size() < DEPTH || pop);
    ov = 1'b0;
    for (int i = 0; i < 136; i++) begin
      cur[i] = in_bit(i);
      if (cur[i] && !mprev[i] && mpend[i] && !(push && i == sel)) ov = 1'b1;
    end
    if (push) mpend[sel] = 1'b0;
    for (int i = 0; i < 136; i++) begin
      if (cur[i] && !mprev[i]) mpend[i] = 1'b1;
      mprev[i] = cur[i];
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({mts[TSW-1:0], sel[7:0]});
    if (clear) mff = push ? {1'b1, sel[7:0]} : 9'h000;
    else if (!mff[8] && push) mff = {1'b1, sel[7:0]};
    if (ov) mov = 1'b1;
    else if (clear) mov = 1'b0;
    mts = (mts + 1) % (1 << TSW);
  endtask

  always @(posedge aclk or posedge areset) begin
    if (areset) model_reset();
    else model_step();
  end

  // Single compare point, 1 time unit after every active edge.
  always @(posedge aclk) begin
    #1;
    chk("m_valid", evt_valid, mq.size() != 0);
    chk("m_count", evt_count, mq.size());
    chk("m_data", evt_data, (mq.size() != 0) ? mq[0] : '0);
    chk("m_first_fault", first_fault, mff);
    chk("m_overflow", evt_overflow, mov);
    chk("m_irq", irq, (mq.size() != 0) || mov);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic pop1();
    evt_rd_en = 1'b1;
    tick(1);
    evt_rd_en = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    evt_rd_en = 1'b1;
    while (evt_valid && guard < 40) begin
      tick(1);
      guard++;
    end
    evt_rd_en = 1'b0;
    chk("drain_bound", evt_valid, 1'b0);
  endtask

  initial begin
    logic [TSW-1:0] ts0;
    int n16, guard, g, b;
    for (int i = 0; i < 17; i++) gin[i] = 8'h00;

    // Boot failures held through reset release.
    gin[6] = 8'h05;
    tick(2);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_count", evt_count, 5'd0);
    chk("rst_irq", irq, 1'b0);
    areset = 1'b0;
    tick(3);
    chk("boot_count", evt_count, 5'd2);
    chk("boot_head0", evt_data[7:0], 8'h30);
    chk("boot_ff", first_fault, 9'h130);
    chk("boot_irq", irq, 1'b1);
    gin[6] = 8'h00;
    pop1();
    chk("boot_head1", evt_data[7:0], 8'h32);
    pop1();
    chk("boot_empty", evt_valid, 1'b0);

    // Simultaneous rise: group 3 board 7 beats group 13 board 3.
    gin[13] = 8'h08;
    gin[3]  = 8'h80;
    tick(3);
    chk("prio_count", evt_count, 5'd2);
    chk("prio_head0", evt_data[7:0], 8'h1F);
    ts0 = evt_data[W-1:8];
    pop1();
    chk("prio_head1", evt_data[7:0], 8'h6B);
    chk("prio_ts_step", evt_data[W-1:8], ts0 + 1'b1);
    pop1();
    gin[13] = 8'h00;
    gin[3]  = 8'h00;

    // Fill to 16, then two rises of group 16 board 0 while it is held.
    gin[1] = 8'hFF;
    gin[2] = 8'hFF;
    tick(18);
    chk("full_count", evt_count, 5'd16);
    gin[1] = 8'h00;
    gin[2] = 8'h00;
    gin[16] = 8'h01; tick(1);
    gin[16] = 8'h00; tick(1);
    gin[16] = 8'h01; tick(1);
    gin[16] = 8'h00; tick(1);
    chk("full_hold_count", evt_count, 5'd16);
    chk("full_overflow", evt_overflow, 1'b1);
    pop1();
    chk("full_pushpop_count", evt_count, 5'd16);
    n16 = 0;
    guard = 0;
    evt_rd_en = 1'b1;
    while (evt_valid && guard < 40) begin
      if (evt_data[7:0] == 8'h80) n16++;
      tick(1);
      guard++;
    end
    evt_rd_en = 1'b0;
    chk("full_g16_entries", n16, 1);

    // spi_off single-cycle pulse.
    gin[0] = 8'h01;
    tick(1);
    gin[0] = 8'h00;
    chk("spi_lat1", evt_valid, 1'b0);
    tick(1);
    chk("spi_lat2", evt_valid, 1'b1);
    chk("spi_code", evt_data[7:0], 8'h00);
    tick(3);
    chk("spi_no_fall", evt_count, 5'd1);

    // clear leaves the FIFO alone; next event reloads first_fault.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clr_ff", first_fault, 9'h000);
    chk("clr_ov", evt_overflow, 1'b0);
    chk("clr_count", evt_count, 5'd1);
    gin[12] = 8'h20;
    tick(2);
    chk("clr_reload", first_fault, 9'h165);
    gin[12] = 8'h00;
    drain();

    // Reset with 5 queued, 3 pending.
    gin[8] = 8'hFF;
    tick(6);
    chk("ar_pre_count", evt_count, 5'd5);
    gin[8] = 8'h00;
    areset = 1'b1;
    #1;
    chk("ar_valid", evt_valid, 1'b0);
    chk("ar_count", evt_count, 5'd0);
    tick(1);
    areset = 1'b0;
    tick(5);
    chk("ar_post_count", evt_count, 5'd0);
    chk("ar_post_valid", evt_valid, 1'b0);

    // Randomized phase, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) begin
        g = $urandom_range(16);
        b = $urandom_range(7);
        gin[g][b] = ~gin[g][b];
      end
      if (((c / 200) % 2) == 1) evt_rd_en = ($urandom_range(9) == 0);
      else evt_rd_en = ($urandom_range(2) != 0);
      clear  = ($urandom_range(40) == 0);
      areset = (c == 1500);
      tick(1);
    end
    evt_rd_en = 1'b0;
    clear = 1'b0;
    areset = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
